// File: rtl/matmul_pkg.sv
// Shared types for the matrix-multiply result drain path: FSM states, index width helper
// and the per-element end markers that travel with each result element.
package matmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_STREAM,
        ST_FLUSH
    } state_e;

    // End-of-row / end-of-matrix markers; joined with the data word to form an element.
    typedef struct packed {
        logic row_last;
        logic last;
    } elem_tag_t;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_skid_fifo.sv
// Two-entry FIFO decoupling the fixed-latency result read port from the stream handshake.
// Push and pop may occur in the same cycle; a pop while empty is ignored.
module matmul_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_pop;

    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/matmul_result_reader.sv
// Drain side of the matrix multiplier: starts a multiply, waits for done (with timeout),
// then reads the NxN result row-major and streams it out with row/matrix end markers.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | ready for a command
//   ST_START  | one-cycle mm_start pulse, clear timeout counter and error
//   ST_WAIT   | wait for mm_done, count cycles toward timeout
//   ST_STREAM | issue indexed reads row-major, results land in the FIFO
//   ST_FLUSH  | all reads issued, wait for the FIFO and read pipe to drain
module matmul_result_reader
    import matmul_pkg::*;
#(
    parameter int N              = 64,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 1 << 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic                  mm_start,
    input  logic                  mm_done,
    output logic                  rd_en,
    output logic [idx_w(N)-1:0]   rd_row,
    output logic [idx_w(N)-1:0]   rd_col,
    input  logic [DATA_W-1:0]     rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_W-1:0]     m_data,
    output logic                  m_row_last,
    output logic                  m_last,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int IDX_W = idx_w(N);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        elem_tag_t         tag;
    } elem_t;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic             inflight_q;
    elem_tag_t        infl_tag_q;
    elem_tag_t        issue_tag;
    logic             issue;
    logic             pop;
    logic             head_valid;
    logic [1:0]       fifo_count;
    logic [2:0]       occ;
    elem_t            push_elem;
    elem_t            head_elem;

    // A pop in this cycle frees a slot before the read issued now returns,
    // which is what lets the stream sustain one element per cycle.
    always_comb begin
        head_valid         = (fifo_count != 2'd0);
        pop                = head_valid && m_ready;
        occ                = {1'b0, fifo_count} + {2'b0, inflight_q};
        issue              = (state_q == ST_STREAM) && (occ < (3'd2 + {2'b0, pop}));
        issue_tag.row_last = (col_q == IDX_LAST);
        issue_tag.last     = (col_q == IDX_LAST) && (row_q == IDX_LAST);

        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        to_cnt_d      = to_cnt_q;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d       = ST_START;
                    timeout_err_d = 1'b0;
                end
            end
            ST_START: begin
                to_cnt_d      = '0;
                timeout_err_d = 1'b0;
                state_d       = ST_WAIT;
            end
            ST_WAIT: begin
                if (mm_done) begin
                    state_d = ST_STREAM;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_STREAM: begin
                if (issue) begin
                    if (issue_tag.last) begin
                        row_d   = '0;
                        col_d   = '0;
                        state_d = ST_FLUSH;
                    end else if (issue_tag.row_last) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if ((fifo_count == 2'd0) && !inflight_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            col_q         <= '0;
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
            inflight_q    <= 1'b0;
            infl_tag_q    <= '0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
            inflight_q    <= issue;
            infl_tag_q    <= issue_tag;
        end
    end

    assign push_elem = {rd_data, infl_tag_q};

    matmul_skid_fifo #(
        .W($bits(elem_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (push_elem),
        .pop       (pop),
        .head      (head_elem),
        .count     (fifo_count)
    );

    assign cmd_ready   = (state_q == ST_IDLE);
    assign mm_start    = (state_q == ST_START);
    assign busy        = (state_q != ST_IDLE);
    assign rd_en       = issue;
    assign rd_row      = row_q;
    assign rd_col      = col_q;
    assign m_valid     = head_valid;
    assign m_data      = head_elem.data;
    assign m_row_last  = head_elem.tag.row_last;
    assign m_last      = head_elem.tag.last;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_matmul_result_reader.sv
// Bench for matmul_result_reader: random handshake and done timing against a row-major
// element model, plus timeout, mid-stream reset and back-to-back command scenarios.
module tb_matmul_result_reader;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int TO = 32;
    localparam int NN = N * N;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          mm_start;
    logic          mm_done = 1'b0;
    logic          rd_en;
    logic [1:0]    rd_row;
    logic [1:0]    rd_col;
    logic [DW-1:0] rd_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_row_last;
    logic          m_last;
    logic          busy;
    logic          timeout_err;

    int n_vec = 0;
    int n_err = 0;

    int cyc = 0;
    int got = 0;
    int n_start = 0;
    int start_cyc = 0;
    int first_valid_cyc = -1;
    int first_pop_cyc = -1;
    int last_pop_cyc = -1;
    int ready_pct = 100;
    bit mon_en = 1'b0;
    bit stall_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;

    logic rs_en = 1'b0;
    int   rs_row = 0;
    int   rs_col = 0;

    matmul_result_reader #(
        .N              (N),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .mm_start    (mm_start),
        .mm_done     (mm_done),
        .rd_en       (rd_en),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .rd_data     (rd_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_row_last  (m_row_last),
        .m_last      (m_last),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Element i of the row-major stream: {data, row_last, last}.
    function automatic logic [DW+1:0] exp_elem(input int i);
        int r = i / N;
        int c = i % N;
        logic [DW-1:0] d = DW'(32'h100 * r + c);
        return {d, (c == N - 1), (i == NN - 1)};
    endfunction

    // Result memory: returns the addressed element the cycle after rd_en, garbage otherwise.
    always @(negedge clk) begin
        rs_en  = rd_en;
        rs_row = int'(rd_row);
        rs_col = int'(rd_col);
    end

    always @(posedge clk) begin
        #1;
        rd_data = rs_en ? DW'(32'h100 * rs_row + rs_col) : DW'($urandom);
    end

    always @(posedge clk) begin
        #1;
        m_ready = ($urandom_range(99) < ready_pct);
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (mm_start) begin
                n_start++;
                start_cyc = cyc;
            end
            if (m_valid && !mon_en) chk("spurious_valid", m_valid, 1'b0);
            if (stall_prev) begin
                chk("stall_valid", m_valid, 1'b1);
                chk("stall_data", m_data, prev_data);
            end
            if (mon_en && m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (mon_en && m_valid && m_ready) begin
                if (got < NN) chk("elem", {m_data, m_row_last, m_last}, exp_elem(got));
                else          chk("extra_elem", got, NN - 1);
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                got++;
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic check_reset_vals(input string t);
        chk({t, "_ctl"}, {mm_start, rd_en, m_valid, m_row_last, m_last, busy, timeout_err, cmd_ready},
            8'b0000_0001);
        chk({t, "_idx_data"}, {rd_row, rd_col, m_data}, '0);
    endtask

    task automatic clear_run_stats();
        got             = 0;
        n_start         = 0;
        first_valid_cyc = -1;
        first_pop_cyc   = -1;
        last_pop_cyc    = -1;
    endtask

    // One command; d = cycles after mm_start that mm_done rises (0: already high at start).
    task automatic run_one(input string name, input int d, input int pct, input bit hold_cmd);
        int k;
        clear_run_stats();
        ready_pct = pct;
        mon_en    = 1'b1;
        cmd_valid = 1'b1;
        k = 0;
        while (!mm_start && k < 50) begin
            tick();
            k++;
        end
        chk({name, "_start_seen"}, mm_start, 1'b1);
        chk({name, "_err_cleared"}, timeout_err, 1'b0);
        if (!hold_cmd) cmd_valid = 1'b0;
        if (d > 0) begin
            mm_done = 1'b0;
            repeat (d) tick();
            mm_done = 1'b1;
        end
        k = 0;
        while (!(got == NN && cmd_ready) && k < 500) begin
            tick();
            k++;
        end
        chk({name, "_count"}, got, NN);
        chk({name, "_idle"}, cmd_ready, 1'b1);
        chk({name, "_one_start"}, n_start, 1);
        chk({name, "_latency"}, first_valid_cyc - start_cyc, ((d < 1) ? 1 : d) + 3);
        if (pct == 100) chk({name, "_rate"}, last_pop_cyc - first_pop_cyc, NN - 1);
        mon_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        ready_pct = 100;
        repeat (3) tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();

        run_one("t1", 5, 100, 1'b0);

        for (int i = 0; i < 3; i++) begin
            run_one("t2", int'($urandom_range(8, 1)), 50, 1'b0);
        end

        // Timeout: no mm_done, error after the 32nd WAIT cycle, sticky until next command.
        mm_done = 1'b0;
        mon_en  = 1'b0;
        cmd_valid = 1'b1;
        k = 0;
        while (!mm_start && k < 50) begin
            tick();
            k++;
        end
        chk("t3_start", mm_start, 1'b1);
        cmd_valid = 1'b0;
        repeat (TO) tick();
        chk("t3_err_not_yet", timeout_err, 1'b0);
        chk("t3_busy", busy, 1'b1);
        tick();
        chk("t3_err_set", timeout_err, 1'b1);
        chk("t3_idle", cmd_ready, 1'b1);
        repeat (4) tick();
        chk("t3_sticky", timeout_err, 1'b1);
        run_one("t3_clear", 3, 100, 1'b0);

        // Reset in the middle of the stream.
        clear_run_stats();
        ready_pct = 100;
        mon_en    = 1'b1;
        cmd_valid = 1'b1;
        k = 0;
        while (!mm_start && k < 50) begin
            tick();
            k++;
        end
        chk("t4_start", mm_start, 1'b1);
        cmd_valid = 1'b0;
        mm_done   = 1'b0;
        repeat (2) tick();
        mm_done = 1'b1;
        k = 0;
        while (got < 6 && k < 200) begin
            tick();
            k++;
        end
        chk("t4_six", got, 6);
        chk("t4_busy", busy, 1'b1);
        rst       = 1'b1;
        mon_en    = 1'b0;
        ready_pct = 0;
        m_ready   = 1'b0;
        tick();
        rst = 1'b0;
        check_reset_vals("t4_rst");
        mm_done = 1'b0;
        run_one("t4_after", 4, 100, 1'b0);

        // cmd_valid held across a run: back-to-back commands, one start each.
        run_one("t5a", 2, 70, 1'b1);
        run_one("t5b", 3, 70, 1'b0);

        // mm_done already high when the command starts.
        mm_done = 1'b1;
        run_one("t6", 0, 100, 1'b0);
        mm_done = 1'b0;

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
